div_seq_nw: RTL and testbench

//  Parametrised sequential restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
//  Per-operation signed or unsigned mode, start/done handshake, divide-by-zero (DZ) and overflow (DO) flags.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_seq_nw_if.sv | 27 ++
 rtl/div_seq_nw_negc.sv | 8 +
 rtl/div_seq_nw.sv | 121 ++++++++++++
 tb/tb_div_seq_nw.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and default width.
package div_pkg;
  localparam int DIV_W_DEFAULT = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_CALC = S_CALC,
    ST_FIN  = S_FIN
  } state_t;
endpackage

// File: rtl/div_seq_nw_if.sv
// Request/response bundle for div_seq_nw. The abort line exists only when DIV_ABORT_EN is defined.
interface div_seq_nw_if import div_pkg::*; #(parameter int W = DIV_W_DEFAULT);
  logic           start;
  logic           signed_op;
  logic [2*W-1:0] A;
  logic [W-1:0]   B;
  logic           ready;
  logic           busy;
  logic           done;
  logic [W-1:0]   Q;
  logic [W-1:0]   R;
  logic           DZ;
  logic           DO;
`ifdef DIV_ABORT_EN
  logic           abort;

  modport master (output start, signed_op, A, B, abort,
                  input  ready, busy, done, Q, R, DZ, DO);
  modport slave  (input  start, signed_op, A, B, abort,
                  output ready, busy, done, Q, R, DZ, DO);
`else
  modport master (output start, signed_op, A, B,
                  input  ready, busy, done, Q, R, DZ, DO);
  modport slave  (input  start, signed_op, A, B,
                  output ready, busy, done, Q, R, DZ, DO);
`endif
endinterface

// File: rtl/div_seq_nw_negc.sv
// Conditional two's-complement: y = neg ? -x : x, modulo 2^N.
module div_negc #(parameter int N = 8) (
  input  logic [N-1:0] x,
  input  logic         neg,
  output logic [N-1:0] y
);
  assign y = neg ? (~x + N'(1)) : x;
endmodule

// File: rtl/div_seq_nw.sv
// Sequential restoring divider, 2W/W -> W quotient and remainder, signed or unsigned per op.
// Optional DIV_ABORT_EN adds an abort input that cancels the op in flight.
module div_seq_nw import div_pkg::*; #(parameter int W = DIV_W_DEFAULT) (
  input  logic         clk,
  input  logic         rst,
  div_seq_nw_if.slave  bus
);
  localparam int CNTW = $clog2(W+1);
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  state_t          state, state_n;
  logic [CNTW-1:0] cnt;
  logic [W-1:0]    rem, quo, bmag;
  logic            sa, sb, sgn_op, dz_p, do_p;
  logic [W-1:0]    q_r, r_r;
  logic            dz_r, do_r, done_r;

  logic [2*W-1:0]  amag_w;
  logic [W-1:0]    bmag_w, qfix, rfix;
  logic [W:0]      shifted, diff;
  logic            ge, dz_w, do_w, accept, fin_en, late_ov, abort_w;

`ifdef DIV_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  div_negc #(.N(2*W)) u_nega (.x(bus.A), .neg(bus.A[2*W-1] & bus.signed_op), .y(amag_w));
  div_negc #(.N(W))   u_negb (.x(bus.B), .neg(bus.B[W-1] & bus.signed_op),   .y(bmag_w));
  div_negc #(.N(W))   u_negq (.x(quo),   .neg(sa ^ sb),                      .y(qfix));
  div_negc #(.N(W))   u_negr (.x(rem),   .neg(sa),                           .y(rfix));

  assign dz_w   = (bus.B == '0);
  assign do_w   = (amag_w[2*W-1:W] >= bmag_w);
  assign accept = (state == ST_IDLE) && bus.start;
  assign fin_en = (state == ST_FIN) && !abort_w;

  // Compare at W+1 bits so the bit shifted out of rem still counts.
  assign shifted = {rem, quo[W-1]};
  assign diff    = shifted - {1'b0, bmag};
  assign ge      = (shifted >= {1'b0, bmag});

  // Magnitude fits W bits but not the signed range: +2^(W-1) is illegal, -2^(W-1) is fine.
  assign late_ov = sgn_op && ((sa ^ sb) ? (quo > HALF) : (quo >= HALF));

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (bus.start) state_n = (dz_w || do_w) ? ST_FIN : ST_CALC;
      ST_CALC: if (cnt == CNTW'(1)) state_n = ST_FIN;
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (abort_w && (state != ST_IDLE)) state_n = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      bmag   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      sgn_op <= 1'b0;
      dz_p   <= 1'b0;
      do_p   <= 1'b0;
      q_r    <= '0;
      r_r    <= '0;
      dz_r   <= 1'b0;
      do_r   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        rem    <= amag_w[2*W-1:W];
        quo    <= amag_w[W-1:0];
        bmag   <= bmag_w;
        sa     <= bus.A[2*W-1] & bus.signed_op;
        sb     <= bus.B[W-1] & bus.signed_op;
        sgn_op <= bus.signed_op;
        cnt    <= CNTW'(W);
        dz_p   <= dz_w;
        do_p   <= !dz_w && do_w;
      end else if (state == ST_CALC) begin
        rem <= ge ? diff[W-1:0] : shifted[W-1:0];
        quo <= {quo[W-2:0], ge};
        cnt <= cnt - CNTW'(1);
      end
      // Results only move here, so they stay stable across the next accept.
      if (fin_en) begin
        done_r <= 1'b1;
        if (dz_p || do_p || late_ov) begin
          q_r  <= '0;
          r_r  <= '0;
          dz_r <= dz_p;
          do_r <= !dz_p;
        end else begin
          q_r  <= qfix;
          r_r  <= rfix;
          dz_r <= 1'b0;
          do_r <= 1'b0;
        end
      end
    end
  end

  assign bus.ready = (state == ST_IDLE);
  assign bus.busy  = (state != ST_IDLE);
  assign bus.done  = done_r;
  assign bus.Q     = q_r;
  assign bus.R     = r_r;
  assign bus.DZ    = dz_r;
  assign bus.DO    = do_r;
endmodule

// File: tb/tb_div_seq_nw.sv
// Randomized self-checking bench for div_seq_nw against a wide-integer arithmetic model.
module tb_div_seq_nw;
  localparam int W  = 32;
  localparam int CW = 2*W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_seq_nw_if #(.W(W)) bus ();
  div_seq_nw #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    bit           dz;
    bit           dov;
    int           due;
  } exp_t;

  exp_t sbq[$];
  exp_t last;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Truncating division on wide signed integers; overflow is a range check on the true quotient.
  function automatic void model(input logic [CW-1:0] a, input logic [W-1:0] b, input bit s,
                                output exp_t e, output int lat);
    logic signed [CW+1:0] av, bv, qt, rt, qlim;
    logic [CW-1:0] am;
    logic [W-1:0]  bm;
    bit ovf;
    e.q = '0; e.r = '0; e.dz = 1'b0; e.dov = 1'b0; e.due = 0;
    if (b == '0) begin
      e.dz = 1'b1;
      lat  = 1;
      return;
    end
    am  = (s && a[CW-1]) ? -a : a;
    bm  = (s && b[W-1])  ? -b : b;
    lat = (((am / CW'(bm)) >> W) != '0) ? 1 : W + 1;
    av  = s ? {{2{a[CW-1]}}, a} : {2'b00, a};
    bv  = s ? {{(W+2){b[W-1]}}, b} : {{(W+2){1'b0}}, b};
    qt  = av / bv;
    rt  = av % bv;
    qlim = '0;
    qlim[W-1] = 1'b1;
    ovf = s ? ((qt >= qlim) || (qt < -qlim)) : (qt[CW+1:W] != '0);
    if (ovf) e.dov = 1'b1;
    else begin
      e.q = qt[W-1:0];
      e.r = rt[W-1:0];
    end
  endfunction

  // Compare process: done must pulse exactly on the due cycle; results must hold otherwise.
  always @(negedge clk) begin
    bit exp_done;
    if (!rst) begin
      exp_done = (sbq.size() > 0) && (sbq[0].due == cyc);
      chk("done", CW'(bus.done), CW'(exp_done));
      if (exp_done) last = sbq.pop_front();
      chk("Q",  CW'(bus.Q),  CW'(last.q));
      chk("R",  CW'(bus.R),  CW'(last.r));
      chk("DZ", CW'(bus.DZ), CW'(last.dz));
      chk("DO", CW'(bus.DO), CW'(last.dov));
    end
  end

  task automatic issue(input logic [CW-1:0] a, input logic [W-1:0] b, input bit s);
    exp_t e;
    int lat;
    int n = 0;
    while (bus.ready !== 1'b1) begin
      // Junk requests while busy must be ignored.
      bus.start     = ($urandom_range(0, 2) == 0);
      bus.A         = {$urandom(), $urandom()};
      bus.B         = $urandom();
      bus.signed_op = $urandom_range(0, 1);
      @(negedge clk);
      n++;
      if (n > 200) begin
        failures++;
        $display("FAIL ready_timeout: ready stuck at %b, expected 1", bus.ready);
        bus.start = 1'b0;
        return;
      end
    end
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.signed_op = s;
    model(a, b, s, e, lat);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = {$urandom(), $urandom()};
    bus.B = $urandom();
    bus.signed_op = $urandom_range(0, 1);
    e.due = cyc + lat;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    bus.start = 1'b0;
    while (sbq.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d ops outstanding, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    exp_t e;
    int lat;
    logic [CW-1:0] a;
    logic [W-1:0] b;
    last = '{q: '0, r: '0, dz: 1'b0, dov: 1'b0, due: 0};
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.A = '0; bus.B = '0;
`ifdef DIV_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_Q",     CW'(bus.Q),     '0);
    chk("rst_R",     CW'(bus.R),     '0);
    chk("rst_flags", CW'({bus.DZ, bus.DO, bus.done, bus.busy}), '0);
    chk("rst_ready", CW'(bus.ready), CW'(1));
    #1 rst = 1'b0;

    // Pin the model to hand-computed values.
    model(64'd100, 32'd7, 1'b0, e, lat);
    chk("m_u_q", CW'(e.q), 64'd14); chk("m_u_r", CW'(e.r), 64'd2); chk("m_u_lat", CW'(lat), 64'd33);
    model(-64'sd100, 32'd7, 1'b1, e, lat);
    chk("m_s_q", CW'(e.q), 64'hFFFF_FFF2); chk("m_s_r", CW'(e.r), 64'hFFFF_FFFE);
    model(64'd100, -32'sd7, 1'b1, e, lat);
    chk("m_s2_q", CW'(e.q), 64'hFFFF_FFF2); chk("m_s2_r", CW'(e.r), 64'd2);
    model(64'h1234, 32'd0, 1'b1, e, lat);
    chk("m_dz", CW'({e.dz, e.dov}), 64'd2); chk("m_dz_lat", CW'(lat), 64'd1);
    model(64'h0000_0001_0000_0000, 32'd1, 1'b1, e, lat);
    chk("m_do_early", CW'({e.dov, 7'(lat)}), {56'd0, 8'h81});
    model(64'h0000_0000_8000_0000, 32'd1, 1'b1, e, lat);
    chk("m_do_late", CW'({e.dov, 7'(lat)}), {56'd0, 8'hA1});
    model(64'hFFFF_FFFF_8000_0000, 32'd1, 1'b1, e, lat);
    chk("m_minq", CW'({e.dov, e.q}), 64'h8000_0000);

    // Directed cases through the DUT, issued back to back.
    issue(64'd100, 32'd7, 1'b0);
    issue(-64'sd100, 32'd7, 1'b1);
    issue(64'd100, -32'sd7, 1'b1);
    issue(64'hDEAD_BEEF_0000_0001, 32'd0, 1'b0);
    issue(64'h0000_0001_0000_0000, 32'd1, 1'b1);
    issue(64'h0000_0000_8000_0000, 32'd1, 1'b1);
    issue(64'hFFFF_FFFF_8000_0000, 32'd1, 1'b1);
    issue(64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drain();

    // Reset in the middle of a calculation clears everything without a clock edge.
    issue(64'd1000, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_QR", CW'({bus.Q, bus.R}), '0);
    chk("mid_rst_flags", CW'({bus.DZ, bus.DO, bus.done, bus.busy}), '0);
    chk("mid_rst_ready", CW'(bus.ready), CW'(1));
    sbq.delete();
    last = '{q: '0, r: '0, dz: 1'b0, dov: 1'b0, due: 0};
    @(negedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       a = {$urandom(), $urandom()};
        1:       a = CW'($signed($urandom()));
        2:       a = CW'($urandom());
        default: a = {$urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : 32'd0, $urandom()};
      endcase
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 15);
        1:       b = -$urandom_range(0, 15);
        default: b = $urandom();
      endcase
      if ($urandom_range(0, 4) == 0) begin
        bus.start = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      issue(a, b, 1'($urandom_range(0, 1)));
    end
    drain();

`ifdef DIV_ABORT_EN
    issue(64'd5000, 32'd9, 1'b0);
    repeat (4) @(negedge clk);
    bus.abort = 1'b1;
    void'(sbq.pop_back());
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_ready", CW'(bus.ready), CW'(1));
    repeat (W + 4) @(negedge clk);
    issue(64'd77, 32'd5, 1'b0);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
